// File: rtl/rc5_key_mixer_if.sv
// Host-side bus of the RC5 key-schedule block: start/status, L-word
// handshake and the combinational S-table read port.
`timescale 1ns/1ps
interface rc5_key_mixer_if #(
    parameter int W = 32
);
    logic         start;
    logic         l_valid;
    logic         l_ready;
    logic [W-1:0] l_data;
    logic [4:0]   s_raddr;
    logic [W-1:0] s_rdata;
    logic         busy;
    logic         done;

    modport master (
        output start, l_valid, l_data, s_raddr,
        input  l_ready, s_rdata, busy, done
    );

    modport slave (
        input  start, l_valid, l_data, s_raddr,
        output l_ready, s_rdata, busy, done
    );
endinterface

// File: rtl/rc5_key_mixer.sv
// RC5 key expansion: loads C key words, builds the magic-constant S table,
// then mixes L into S for 3*max(T,C) iterations, one per clock.
`timescale 1ns/1ps
module rc5_key_mixer #(
    parameter int           W        = 32,
    parameter int           R        = 12,
    parameter int           C        = 4,
    parameter int           C_LENGTH = 2,
    parameter logic [W-1:0] P        = 32'hB7E15163,
    parameter logic [W-1:0] Q        = 32'h9E3779B9
) (
    input logic            clk,
    input logic            rst,
    rc5_key_mixer_if.slave bus
);

    localparam int T     = 2 * (R + 1);
    localparam int IW    = $clog2(T);
    localparam int LW    = $clog2(W);
    localparam int N_MIX = 3 * ((T > C) ? T : C);
    localparam int MW    = $clog2(N_MIX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_L = 3'd1,
        INIT_S = 3'd2,
        MIX    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                busy_r;
    logic                done_r;
    logic                l_ready_r;
    logic [W-1:0]        s_mem_r [T];
    logic [W-1:0]        l_mem_r [C];
    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic [W-1:0]        acc_r;
    logic [IW-1:0]       i_r;
    logic [IW-1:0]       k_r;
    logic [C_LENGTH-1:0] j_r;
    logic [C_LENGTH-1:0] lidx_r;
    logic [MW-1:0]       mix_cnt_r;
    logic                l_take_s;
    logic                start_take_s;
    logic [W-1:0]        sum_a_s;
    logic [W-1:0]        a_new_s;
    logic [W-1:0]        ab_s;
    logic [W-1:0]        sum_b_s;
    logic [W-1:0]        b_new_s;

    // Rotate left; the doubled word keeps a zero rotation well defined.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << n;
        return dbl[2*W-1:W];
    endfunction

    // Handshake qualifiers.
    always_comb begin
        l_take_s     = (state_r == LOAD_L) && bus.l_valid;
        start_take_s = ((state_r == IDLE) || (state_r == DONE)) && bus.start;
    end

    // One mixing iteration on the current S[i], L[j], A and B.
    always_comb begin
        sum_a_s = s_mem_r[i_r] + a_r + b_r;
        a_new_s = rotl(sum_a_s, LW'(3'd3));
        ab_s    = a_new_s + b_r;
        sum_b_s = l_mem_r[j_r] + ab_s;
        b_new_s = rotl(sum_b_s, ab_s[LW-1:0]);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt_s = LOAD_L;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            LOAD_L: begin
                if (l_take_s && (lidx_r == C_LENGTH'(C - 1))) begin
                    state_nxt_s = INIT_S;
                end else begin
                    state_nxt_s = LOAD_L;
                end
            end
            INIT_S: begin
                if (k_r == IW'(T - 1)) begin
                    state_nxt_s = MIX;
                end else begin
                    state_nxt_s = INIT_S;
                end
            end
            MIX: begin
                if (mix_cnt_r == MW'(N_MIX - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MIX;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            l_ready_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s == LOAD_L) || (state_nxt_s == INIT_S) || (state_nxt_s == MIX);
            done_r    <= (state_nxt_s == DONE);
            l_ready_r <= (state_nxt_s == LOAD_L);
        end
    end

    // Key storage, S-table build and mixing datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < T; n++) begin
                s_mem_r[n] <= '0;
            end
            for (int n = 0; n < C; n++) begin
                l_mem_r[n] <= '0;
            end
            a_r       <= '0;
            b_r       <= '0;
            acc_r     <= '0;
            i_r       <= '0;
            k_r       <= '0;
            j_r       <= '0;
            lidx_r    <= '0;
            mix_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_take_s) begin
                        lidx_r    <= '0;
                        a_r       <= '0;
                        b_r       <= '0;
                        k_r       <= '0;
                        i_r       <= '0;
                        j_r       <= '0;
                        mix_cnt_r <= '0;
                        acc_r     <= P;
                    end
                end
                LOAD_L: begin
                    if (l_take_s) begin
                        l_mem_r[lidx_r] <= bus.l_data;
                        lidx_r          <= lidx_r + 1'b1;
                    end
                end
                INIT_S: begin
                    // acc_r walks P + k*Q without a multiplier.
                    s_mem_r[k_r] <= acc_r;
                    acc_r        <= acc_r + Q;
                    if (k_r == IW'(T - 1)) begin
                        k_r       <= '0;
                        i_r       <= '0;
                        j_r       <= '0;
                        a_r       <= '0;
                        b_r       <= '0;
                        mix_cnt_r <= '0;
                    end else begin
                        k_r <= k_r + 1'b1;
                    end
                end
                MIX: begin
                    s_mem_r[i_r] <= a_new_s;
                    l_mem_r[j_r] <= b_new_s;
                    a_r          <= a_new_s;
                    b_r          <= b_new_s;
                    i_r          <= (i_r == IW'(T - 1)) ? '0 : i_r + 1'b1;
                    j_r          <= (j_r == C_LENGTH'(C - 1)) ? '0 : j_r + 1'b1;
                    mix_cnt_r    <= mix_cnt_r + 1'b1;
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    // Combinational S-table read; out-of-range indices read as zero.
    always_comb begin
        if (bus.s_raddr < 5'(T)) begin
            bus.s_rdata = s_mem_r[IW'(bus.s_raddr)];
        end else begin
            bus.s_rdata = '0;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.l_ready = l_ready_r;

endmodule

// File: tb/tb_rc5_key_mixer.sv
// Directed bench for rc5_key_mixer: feeds keys, checks latency and every
// S word against a software RC5 key-schedule model.
`timescale 1ns/1ps
module tb_rc5_key_mixer;

    localparam logic [31:0] PC = 32'hB7E15163;
    localparam logic [31:0] QC = 32'h9E3779B9;

    logic clk;
    logic rst;
    rc5_key_mixer_if #(.W(32)) bus ();

    rc5_key_mixer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total;
    int          bad;
    logic [31:0] m_s [26];
    logic [31:0] cur_key [4];
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
        if (n == 0) return x;
        else return (x << n) | (x >> (32 - n));
    endfunction

    // Reference key schedule on cur_key, written the textbook way.
    task automatic model();
        logic [31:0] l [4];
        logic [31:0] a;
        logic [31:0] b;
        int i;
        int j;
        for (int n = 0; n < 4; n++) l[n] = cur_key[n];
        for (int k = 0; k < 26; k++) m_s[k] = PC + QC * k;
        a = 32'd0; b = 32'd0; i = 0; j = 0;
        for (int n = 0; n < 78; n++) begin
            a = rol(m_s[i] + a + b, 3);
            m_s[i] = a;
            b = rol(l[j] + a + b, (a + b) % 32);
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic new_key(input bit zero);
        for (int n = 0; n < 4; n++) cur_key[n] = zero ? 32'd0 : $urandom;
        model();
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offers key words; returns on the negedge right after the final capture edge.
    task automatic feed(input bit stall);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 400) begin
            if (stall && (cyc % 3) != 0) begin
                bus.l_valid = 1'b0;
                bus.l_data  = $urandom;
            end else begin
                bus.l_valid = 1'b1;
                bus.l_data  = cur_key[idx];
            end
            if (bus.l_valid && bus.l_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.l_valid = 1'b0;
        check("feed_words", 32'(idx), 32'd4);
        check("busy_after_feed", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(input int cnt0, input string tag);
        int cnt;
        cnt = cnt0;
        while (!bus.done && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd104);
        check({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic read_all(input bit zero, input string tag);
        logic [31:0] e;
        for (int a = 0; a < 32; a++) begin
            bus.s_raddr = 5'(a);
            exp_q.push_back((zero || a >= 26) ? 32'd0 : m_s[a]);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_s%0d", tag, a), bus.s_rdata, e);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        bus.start = 1'b0;
        bus.l_valid = 1'b0;
        bus.l_data = 32'd0;
        bus.s_raddr = 5'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_l_ready", {31'd0, bus.l_ready}, 32'd0);
        read_all(1'b1, "rst");
        rst = 1'b1;
        bus.l_valid = 1'b1;
        bus.l_data = 32'hDEADBEEF;
        repeat (5) @(negedge clk);
        bus.l_valid = 1'b0;
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_l_ready", {31'd0, bus.l_ready}, 32'd0);

        // Zero key: inspect S right after INIT_S and after the first iteration.
        new_key(1'b1);
        start_pulse();
        feed(1'b0);
        repeat (26) @(negedge clk);
        bus.s_raddr = 5'd0;
        #1 check("zk_init_s0", bus.s_rdata, 32'hB7E15163);
        bus.s_raddr = 5'd1;
        #1 check("zk_init_s1", bus.s_rdata, 32'h5618CB1C);
        @(negedge clk);
        bus.s_raddr = 5'd0;
        #1 check("zk_mix1_s0", bus.s_rdata, 32'hBF0A8B1D);
        wait_done(27, "zk");
        read_all(1'b0, "zk");

        // Stalled handshake.
        new_key(1'b0);
        start_pulse();
        feed(1'b1);
        wait_done(0, "stall");
        read_all(1'b0, "stall");

        // start during MIX ignored; start in DONE restarts.
        new_key(1'b0);
        start_pulse();
        feed(1'b0);
        repeat (40) @(negedge clk);
        start_pulse();
        wait_done(42, "midstart");
        read_all(1'b0, "midstart");
        new_key(1'b0);
        start_pulse();
        check("restart_done_clr", {31'd0, bus.done}, 32'd0);
        feed(1'b0);
        wait_done(0, "restart");
        read_all(1'b0, "restart");

        // Reset at MIX iteration 40.
        new_key(1'b0);
        start_pulse();
        feed(1'b0);
        repeat (66) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_done", {31'd0, bus.done}, 32'd0);
        check("mrst_l_ready", {31'd0, bus.l_ready}, 32'd0);
        read_all(1'b1, "mrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_idle_busy", {31'd0, bus.busy}, 32'd0);
        new_key(1'b0);
        start_pulse();
        feed(1'b0);
        wait_done(0, "postrst");
        read_all(1'b0, "postrst");

        // Random keys.
        for (int r = 0; r < 50; r++) begin
            new_key(1'b0);
            start_pulse();
            feed(r % 2 == 1);
            wait_done(0, $sformatf("rnd%0d", r));
            read_all(1'b0, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc5_key_mixer.md
RC5_KEY_MIXER -- requirements
Module: rc5_key_mixer

Interface
REQ-001 SHALL have parameter W, default 32, word width in bits (power of 2).
REQ-002 SHALL have parameter R, default 12, round count; T = 2*(R+1) = 26 S-table words.
REQ-003 SHALL have parameter C, default 4, L-array word count; C_LENGTH, default 2, L index width.
REQ-004 SHALL have parameters P, default 32'hB7E15163, and Q, default 32'h9E3779B9, magic constants.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a key schedule.
REQ-008 SHALL have ports l_valid, input, 1, and l_ready, output, 1, L-word handshake from the key-bytes-to-words stage.
REQ-009 SHALL have port l_data, input, W, L word; words are taken in order L[0]..L[C-1].
REQ-010 SHALL have port s_raddr, input, 5, S-table read index.
REQ-011 SHALL have port s_rdata, output, W, S[s_raddr], combinational; 0 for s_raddr >= T.
REQ-012 SHALL have ports busy, output, 1, schedule in progress, and done, output, 1, S table valid.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_L, INIT_S, MIX, DONE.
REQ-014 IDLE or DONE with start=1 SHALL go to LOAD_L, clear done, and zero the L index, A, and B.
REQ-015 In LOAD_L, l_ready SHALL be 1; each cycle with l_valid & l_ready SHALL store l_data into L[index] and increment index; after L[C-1] is stored, go to INIT_S.
REQ-016 In every state except LOAD_L, l_ready SHALL be 0; l_valid SHALL be ignored.
REQ-017 INIT_S SHALL write S[k] = P + k*Q mod 2^W, one word per cycle for k=0..T-1 (T cycles), then go to MIX with i=j=0, A=B=0.
REQ-018 MIX SHALL perform exactly 3*max(T,C) = 78 iterations, one per cycle.
REQ-019 Each iteration: A' = rotl(S[i]+A+B, 3); B' = rotl(L[j]+A'+B, (A'+B) mod W); write S[i]=A', L[j]=B', A=A', B=B'.
REQ-020 All sums SHALL be modulo 2^W; rotation amount SHALL use the low log2(W) bits only.
REQ-021 After each iteration, i SHALL wrap T-1 -> 0 and j SHALL wrap C-1 -> 0, independently.
REQ-022 After the last iteration, the FSM SHALL enter DONE and set done=1, which holds until the next start or reset.
REQ-023 busy SHALL be 1 exactly in LOAD_L, INIT_S, and MIX.
REQ-024 done SHALL rise exactly T + 3*max(T,C) = 104 cycles after the edge that accepts the final L word.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 start in DONE SHALL restart the schedule; the old S contents are not guaranteed until done rises again.
REQ-027 A stall on l_valid=0 in LOAD_L SHALL hold all state indefinitely.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, busy=0, done=0, l_ready=0, A=B=0, all indices 0, and all S and L words 0.
REQ-029 rst asserted mid-operation (any state) SHALL abort without completing any partial write.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-031 Zero key: start, L={0,0,0,0} -> at INIT_S end S[0]=B7E15163, S[1]=5618CB1C; after the first MIX iteration S[0]=BF0A8B1D and L[0]=B7E15163.
REQ-032 Latency: L words fed back-to-back -> done rises exactly 104 cycles after the 4th handshake; busy falls on the same edge.
REQ-033 Handshake stall: l_valid toggles 1,0,0,1,... -> only cycles with l_valid=1 are captured; final S matches the bit-accurate model.
REQ-034 Random 16-byte keys (≥50) -> all 26 S words read via s_raddr match the bit-accurate model; s_raddr=26..31 -> s_rdata=0.
REQ-035 start pulsed during MIX -> ignored, result unchanged; start in DONE -> second schedule completes correctly.
REQ-036 rst=0 asserted at MIX iteration 40 -> immediate IDLE, busy=0, done=0, all S words 0; a subsequent start yields a correct result.
